ahb_sram_be: RTL and testbench

Parametrised byte-lane SRAM model with AHB-style lane mapping. It serves as the memory slave behind the AHB slave interface in the verification platform. It adds configurable width and depth, a selectable read pipeline with a data-valid strobe, and byte-enable and range legality checking with an error pulse. A post-reset clear sequencer zeroes the whole array before the block accepts traffic.

---
 rtl/ahb_sram_be.sv | 150 +++++++++++++++
 tb/tb_ahb_sram_be.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_be.sv
// ahb_sram_be: byte-lane SRAM model with AHB-style lane mapping.
// A post-reset clear sequence zeroes the array, then the block accepts
// one request per cycle with lane and range legality checking.
// Reads use a 1- or 2-cycle pipeline with a data-valid strobe.
module ahb_sram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LAT     = 1,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  hresetn,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_en,
  input  logic                  ram_we,
  input  logic [BE_WIDTH-1:0]   ram_be,
  input  logic [DATA_WIDTH-1:0] ram_din,
  output logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_dvalid,
  output logic                  ram_rdy,
  output logic                  ram_err
);

  localparam int LANE_BITS = $clog2(BE_WIDTH);
  localparam int CNT_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WIDX_W    = ADDR_WIDTH - LANE_BITS;
  localparam logic [WIDX_W:0]  DEPTH_W = (WIDX_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_W  = CNT_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  logic [CNT_W-1:0]      clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [WIDX_W-1:0]     widx;
  logic [CNT_W-1:0]      midx;
  logic                  idx_ok;
  logic                  be_ok;
  logic                  legal;
  logic                  acc_wr;
  logic                  acc_rd;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  pre_v;
  logic [DATA_WIDTH-1:0] pre_d;
  logic                  unused_lane_bits;

  // Byte offset bits within a word carry no meaning for this slave.
  assign unused_lane_bits = ^ram_addr[LANE_BITS-1:0];

  assign widx   = ram_addr[ADDR_WIDTH-1:LANE_BITS];
  assign midx   = widx[CNT_W-1:0];
  assign idx_ok = ({1'b0, widx} < DEPTH_W);

  // Lane enables must form a naturally aligned power-of-two group.
  always_comb begin
    be_ok = 1'b0;
    for (int unsigned sz = 1; sz <= BE_WIDTH; sz = sz * 2) begin
      for (int unsigned off = 0; off < BE_WIDTH; off = off + sz) begin
        if (ram_be == BE_WIDTH'(((1 << sz) - 1) << off))
          be_ok = 1'b1;
      end
    end
  end

  // Expand lane enables into a bit mask for read data.
  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < BE_WIDTH; i++)
      lane_mask[8*i +: 8] = {8{ram_be[i]}};
  end

  assign legal   = ram_rdy & idx_ok & be_ok;
  assign acc_wr  = ram_en & ram_we & legal;
  assign acc_rd  = ram_en & ~ram_we & legal;
  assign rd_word = mem[midx] & lane_mask;

  // Clear sequencer: walk every word in INIT, then hold RUN until reset.
  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= INIT;
      clr_cnt <= '0;
      ram_rdy <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (clr_cnt == LAST_W)
            state <= RUN;
          else
            clr_cnt <= clr_cnt + CNT_W'(1);
        end
        RUN: ram_rdy <= 1'b1;
        default: state <= INIT;
      endcase
    end
  end

  // Array update: clearing in INIT, lane-masked writes otherwise.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_cnt] <= '0;
    end else if (acc_wr) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++)
        if (ram_be[i])
          mem[midx][8*i +: 8] <= ram_din[8*i +: 8];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic                  s1_v;
      logic [DATA_WIDTH-1:0] s1_d;

      // Extra read stage; reset drops any read in flight.
      always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
          s1_v <= 1'b0;
          s1_d <= '0;
        end else begin
          s1_v <= acc_rd;
          if (acc_rd)
            s1_d <= rd_word;
        end
      end

      assign pre_v = s1_v;
      assign pre_d = s1_d;
    end else begin : g_lat1
      assign pre_v = acc_rd;
      assign pre_d = rd_word;
    end
  endgenerate

  // Output stage: data holds between strobes, err flags rejected requests.
  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      ram_dout   <= '0;
      ram_dvalid <= 1'b0;
      ram_err    <= 1'b0;
    end else begin
      ram_dvalid <= pre_v;
      if (pre_v)
        ram_dout <= pre_d;
      ram_err <= ram_en & ~legal;
    end
  end

endmodule

// File: tb/tb_ahb_sram_be.sv
// tb_ahb_sram_be: drives a 1-cycle and a 2-cycle latency instance with the
// same request stream and checks every cycle against a word-array model.
module tb_ahb_sram_be;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        hresetn;
  logic [12:0] ram_addr;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_din;

  logic [31:0] dout1, dout2;
  logic        dv1, dv2, rdy1, rdy2, err1, err2;

  ahb_sram_be #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(13), .RD_LAT(1)) u_lat1 (
    .clk(clk), .hresetn(hresetn), .ram_addr(ram_addr), .ram_en(ram_en),
    .ram_we(ram_we), .ram_be(ram_be), .ram_din(ram_din), .ram_dout(dout1),
    .ram_dvalid(dv1), .ram_rdy(rdy1), .ram_err(err1)
  );

  ahb_sram_be #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(13), .RD_LAT(2)) u_lat2 (
    .clk(clk), .hresetn(hresetn), .ram_addr(ram_addr), .ram_en(ram_en),
    .ram_we(ram_we), .ram_be(ram_be), .ram_din(ram_din), .ram_dout(dout2),
    .ram_dvalid(dv2), .ram_rdy(rdy2), .ram_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [31:0] mmem [DEPTH];
  int unsigned edges;
  logic        err_exp, rdy_exp, v1_exp, v2_exp, prev_v;
  logic [31:0] d1_exp, d2_exp, prev_d;

  logic [3:0] legal_tab [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

  function automatic bit be_legal(input logic [3:0] be);
    return be inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("err_l1", {31'b0, err1}, {31'b0, err_exp});
    chk("err_l2", {31'b0, err2}, {31'b0, err_exp});
    chk("rdy_l1", {31'b0, rdy1}, {31'b0, rdy_exp});
    chk("rdy_l2", {31'b0, rdy2}, {31'b0, rdy_exp});
    chk("dvalid_l1", {31'b0, dv1}, {31'b0, v1_exp});
    chk("dvalid_l2", {31'b0, dv2}, {31'b0, v2_exp});
    chk("dout_l1", dout1, d1_exp);
    chk("dout_l2", dout2, d2_exp);
  endtask

  // One request cycle: called just after a falling edge.
  task automatic cycle(input bit en, input bit we, input logic [12:0] addr,
                       input logic [3:0] be, input logic [31:0] din);
    bit          legal;
    bit          rv;
    int unsigned w;
    logic [31:0] rd;
    ram_en = en; ram_we = we; ram_addr = addr; ram_be = be; ram_din = din;
    w     = int'(addr) / 4;
    legal = en && (edges >= DEPTH + 1) && (w < DEPTH) && be_legal(be);
    rv    = legal && !we;
    rd    = '0;
    if (rv)
      for (int i = 0; i < 4; i++)
        if (be[i]) rd[8*i +: 8] = mmem[w][8*i +: 8];
    @(posedge clk);
    if (legal && we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mmem[w][8*i +: 8] = din[8*i +: 8];
    edges++;
    err_exp = en && !legal;
    rdy_exp = (edges >= DEPTH + 1);
    v1_exp  = rv;
    if (rv) d1_exp = rd;
    v2_exp  = prev_v;
    if (prev_v) d2_exp = prev_d;
    prev_v  = rv;
    prev_d  = rd;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Reset pulse spanning one rising edge; outputs must be zero throughout.
  task automatic do_reset();
    hresetn = 1'b0;
    ram_en  = 1'b0;
    #1;
    err_exp = 1'b0; rdy_exp = 1'b0; v1_exp = 1'b0; v2_exp = 1'b0;
    d1_exp  = '0;   d2_exp  = '0;   prev_v = 1'b0; prev_d = '0;
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    hresetn = 1'b1;
    edges = 0;
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
  endtask

  initial begin
    logic [3:0]  rbe;
    logic [12:0] raddr;
    hresetn = 1'b0;
    ram_en = 1'b0; ram_we = 1'b0; ram_addr = '0; ram_be = '0; ram_din = '0;
    edges = 0;
    @(negedge clk);
    do_reset();

    // Clear sequence; a few requests during INIT, including on the rdy edge
    for (int unsigned i = 0; i < DEPTH + 2; i++) begin
      if (i == 3 || i == 500 || i == DEPTH - 1 || i == DEPTH)
        cycle(1'b1, i[0], 13'h0014, 4'hF, 32'h1234_5678);
      else
        cycle(1'b0, 1'b0, '0, '0, '0);
    end
    cycle(1'b1, 1'b0, 13'h0014, 4'hF, '0);
    chk("t1_word5", dout1, 32'h0000_0000);
    idle(2);

    // Lane writes
    cycle(1'b1, 1'b1, 13'h0010, 4'hF, 32'hAABB_CCDD);
    cycle(1'b1, 1'b1, 13'h0010, 4'h4, 32'h1122_3344);
    cycle(1'b1, 1'b0, 13'h0010, 4'hF, '0);
    chk("t2_full", dout1, 32'hAA22_CCDD);
    cycle(1'b1, 1'b0, 13'h0010, 4'hC, '0);
    chk("t2_upper", dout1, 32'hAA22_0000);
    chk("t2_full_l2", dout2, 32'hAA22_CCDD);
    idle(2);

    // Illegal accesses back-to-back, then confirm memory unchanged
    cycle(1'b1, 1'b1, 13'h0010, 4'h6, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, 13'h0010, 4'h0, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, 13'h1000, 4'hF, 32'hFFFF_FFFF);
    chk("t3_err", {31'b0, err1}, 32'd1);
    cycle(1'b1, 1'b0, 13'h0010, 4'hF, '0);
    idle(2);

    // Back-to-back reads of preloaded words 0..3
    for (int unsigned i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, 13'(i * 4), 4'hF, 32'(i + 1));
    for (int unsigned i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 13'(i * 4), 4'hF, '0);
    idle(2);

    // Read-after-write
    cycle(1'b1, 1'b1, 13'h001C, 4'hF, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, 13'h001C, 4'hF, '0);
    chk("t5_raw_l1", dout1, 32'hDEAD_BEEF);
    idle(1);
    chk("t5_raw_l2", dout2, 32'hDEAD_BEEF);
    idle(1);

    // Mid-operation reset with a read in flight
    cycle(1'b1, 1'b0, 13'h001C, 4'hF, '0);
    do_reset();
    idle(DEPTH + 2);
    cycle(1'b1, 1'b0, 13'h001C, 4'hF, '0);
    chk("t6_word7", dout1, 32'h0000_0000);
    idle(2);

    // Randomized traffic over a small window plus out-of-range words
    for (int unsigned i = 0; i < 400; i++) begin
      rbe = ($urandom_range(0, 1) == 1) ? legal_tab[$urandom_range(0, 6)]
                                        : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0)
        raddr = 13'(($urandom_range(1024, 2047) * 4) + $urandom_range(0, 3));
      else
        raddr = 13'(($urandom_range(0, 15) * 4) + $urandom_range(0, 3));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, raddr, rbe, $urandom);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
